// File: rtl/spi_sclk_gen.sv
// SPI serial-clock generator: produces SCLK, sample/shift strobes and a DONE pulse
// for one transfer of NBITS+1 bits at a half-period of DIV+1 CLK cycles.
module spi_sclk_gen #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [DIV_W-1:0] DIV,
    input  logic             CPOL,
    input  logic             CPHA,
    input  logic [CNT_W-1:0] NBITS,
    input  logic             START,
    input  logic             ABORT,
    output logic             SCLK,
    output logic             BUSY,
    output logic             SAMPLE_STB,
    output logic             SHIFT_STB,
    output logic             DONE
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LEAD,
        S_TRAIL
    } state_t;

    state_t             r_state, w_state;
    logic [DIV_W-1:0]   r_hcnt, w_hcnt;
    logic [CNT_W-1:0]   r_bcnt, w_bcnt;
    logic [DIV_W-1:0]   r_div, w_div;
    logic [CNT_W-1:0]   r_nbits, w_nbits;
    logic               r_cpol, w_cpol;
    logic               r_cpha, w_cpha;
    logic               r_sclk, w_sclk;
    logic               r_busy, w_busy;
    logic               r_sample, w_sample;
    logic               r_shift, w_shift;
    logic               r_done, w_done;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= S_IDLE;
            r_hcnt   <= '0;
            r_bcnt   <= '0;
            r_div    <= '0;
            r_nbits  <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_sclk   <= 1'b0;
            r_busy   <= 1'b0;
            r_sample <= 1'b0;
            r_shift  <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_hcnt   <= w_hcnt;
            r_bcnt   <= w_bcnt;
            r_div    <= w_div;
            r_nbits  <= w_nbits;
            r_cpol   <= w_cpol;
            r_cpha   <= w_cpha;
            r_sclk   <= w_sclk;
            r_busy   <= w_busy;
            r_sample <= w_sample;
            r_shift  <= w_shift;
            r_done   <= w_done;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_hcnt   = r_hcnt;
        w_bcnt   = r_bcnt;
        w_div    = r_div;
        w_nbits  = r_nbits;
        w_cpol   = r_cpol;
        w_cpha   = r_cpha;
        w_sclk   = r_sclk;
        w_busy   = r_busy;
        w_sample = 1'b0;
        w_shift  = 1'b0;
        w_done   = 1'b0;

        case (r_state)
            S_IDLE: begin
                // Idle SCLK tracks the live CPOL so the line is correct before a start.
                w_sclk = CPOL;
                w_busy = 1'b0;
                if (START && !ABORT) begin
                    w_div   = DIV;
                    w_cpol  = CPOL;
                    w_cpha  = CPHA;
                    w_nbits = NBITS;
                    w_hcnt  = '0;
                    w_bcnt  = '0;
                    w_busy  = 1'b1;
                    w_state = S_LEAD;
                end
            end
            S_LEAD, S_TRAIL: begin
                if (ABORT) begin
                    w_sclk  = r_cpol;
                    w_busy  = 1'b0;
                    w_hcnt  = '0;
                    w_bcnt  = '0;
                    w_state = S_IDLE;
                end else if (r_hcnt == r_div) begin
                    w_hcnt = '0;
                    if (r_state == S_LEAD) begin
                        w_sclk   = ~r_cpol;
                        w_sample = ~r_cpha;
                        w_shift  = r_cpha;
                        w_state  = S_TRAIL;
                    end else begin
                        w_sclk   = r_cpol;
                        w_sample = r_cpha;
                        // Compare before incrementing so NBITS=all-ones never wraps.
                        if (r_bcnt == r_nbits) begin
                            w_done  = 1'b1;
                            w_busy  = 1'b0;
                            w_bcnt  = '0;
                            w_state = S_IDLE;
                        end else begin
                            w_shift = ~r_cpha;
                            w_bcnt  = r_bcnt + 1'b1;
                            w_state = S_LEAD;
                        end
                    end
                end else begin
                    w_hcnt = r_hcnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign SCLK       = r_sclk;
    assign BUSY       = r_busy;
    assign SAMPLE_STB = r_sample;
    assign SHIFT_STB  = r_shift;
    assign DONE       = r_done;

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Scoreboard bench for spi_sclk_gen: transfers are expanded into a timeline of
// expected edge events from the start edge, half-period and bit count.
module tb_spi_sclk_gen;

    localparam int DW = 4;
    localparam int CW = 3;
    localparam int NC = 16384;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] DIV;
    logic          CPOL;
    logic          CPHA;
    logic [CW-1:0] NBITS;
    logic          START;
    logic          ABORT;
    logic          SCLK, BUSY, SAMPLE_STB, SHIFT_STB, DONE;

    spi_sclk_gen #(.DIV_W(DW), .CNT_W(CW)) dut (
        .CLK(CLK), .RST(RST), .DIV(DIV), .CPOL(CPOL), .CPHA(CPHA),
        .NBITS(NBITS), .START(START), .ABORT(ABORT), .SCLK(SCLK),
        .BUSY(BUSY), .SAMPLE_STB(SAMPLE_STB), .SHIFT_STB(SHIFT_STB), .DONE(DONE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        bit sclk;
        bit samp;
        bit shft;
        bit done;
    } ev_t;

    ev_t q[$];
    bit  exp_valid [NC];
    bit  exp_sclk  [NC];
    bit  exp_busy  [NC];
    int  total = 0;
    int  bad   = 0;

    // Reference transfer state
    bit  m_active = 0;
    int  m_t, m_D, m_end;
    bit  m_cpol;

    task automatic trunc(input int e);
        while (q.size() > 0 && q[q.size()-1].cyc >= e) q.delete(q.size()-1);
    endtask

    task automatic step(input bit rst, input bit st, input bit ab,
                        input int dv, input bit cp, input bit ch, input int nb);
        int  e, k, n;
        bit  es, eb;
        ev_t ev;
        e = cyc + 1;
        RST = rst; START = st; ABORT = ab;
        DIV = DW'(dv); CPOL = cp; CPHA = ch; NBITS = CW'(nb);
        if (rst) begin
            es = 0; eb = 0;
            trunc(e);
            m_active = 0;
        end else if (m_active && e <= m_end) begin
            if (ab) begin
                es = m_cpol; eb = 0;
                trunc(e);
                m_active = 0;
            end else begin
                k  = (e - m_t) / m_D;
                es = m_cpol ^ bit'(k % 2);
                eb = (e < m_end);
                if (e == m_end) m_active = 0;
            end
        end else begin
            m_active = 0;
            es = cp;
            eb = 0;
            if (st && !ab) begin
                n        = nb + 1;
                m_t      = e;
                m_D      = dv + 1;
                m_end    = e + 2 * n * m_D;
                m_cpol   = cp;
                m_active = 1;
                eb       = 1;
                for (int i = 1; i <= 2 * n; i++) begin
                    ev.cyc  = e + i * m_D;
                    ev.sclk = cp ^ bit'(i % 2);
                    if (i % 2 == 1) begin
                        ev.samp = !ch;
                        ev.shft = ch;
                    end else begin
                        ev.samp = ch;
                        ev.shft = !ch && (i != 2 * n);
                    end
                    ev.done = (i == 2 * n);
                    q.push_back(ev);
                end
            end
        end
        if (e < NC) begin
            exp_valid[e] = 1;
            exp_sclk[e]  = es;
            exp_busy[e]  = eb;
        end
        @(negedge CLK);
    endtask

    task automatic hold(input int n, input int dv, input bit cp, input bit ch, input int nb);
        for (int i = 0; i < n; i++) step(0, 0, 0, dv, cp, ch, nb);
    endtask

    // Monitor: levels every cycle, strobe events popped from the scoreboard.
    int  me;
    ev_t mev;
    always @(negedge CLK) begin
        me = cyc;
        if (me < NC && exp_valid[me]) begin
            total++;
            if (SCLK !== exp_sclk[me] || BUSY !== exp_busy[me]) begin
                bad++;
                $display("FAIL level edge=%0d got sclk=%b busy=%b want sclk=%b busy=%b",
                         me, SCLK, BUSY, exp_sclk[me], exp_busy[me]);
            end
            while (q.size() > 0 && q[0].cyc < me) begin
                total++; bad++;
                $display("FAIL missed_event edge=%0d got none want event at %0d", me, q[0].cyc);
                q.delete(0);
            end
            if (SAMPLE_STB !== 1'b0 || SHIFT_STB !== 1'b0 || DONE !== 1'b0) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_strobe edge=%0d got samp=%b shft=%b done=%b want none",
                             me, SAMPLE_STB, SHIFT_STB, DONE);
                end else begin
                    mev = q[0];
                    q.delete(0);
                    if (mev.cyc != me || SAMPLE_STB !== mev.samp || SHIFT_STB !== mev.shft ||
                        DONE !== mev.done || SCLK !== mev.sclk) begin
                        bad++;
                        $display("FAIL strobe edge=%0d got samp=%b shft=%b done=%b sclk=%b want edge=%0d samp=%b shft=%b done=%b sclk=%b",
                                 me, SAMPLE_STB, SHIFT_STB, DONE, SCLK,
                                 mev.cyc, mev.samp, mev.shft, mev.done, mev.sclk);
                    end
                end
            end
        end
    end

    initial begin
        int dv, nb, guard;
        bit cp, ch;
        RST = 1; START = 0; ABORT = 0; DIV = '0; CPOL = 0; CPHA = 0; NBITS = '0;
        @(negedge CLK);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 5, 1, 1, 3);   // reset overrides START
        hold(2, 0, 0, 0, 0);

        // Basic CLK/2 transfer, 8 bits
        step(0, 1, 0, 0, 0, 0, 7);
        hold(20, 0, 0, 0, 7);

        // DIV=3, CPOL=1, CPHA=1, single bit
        step(0, 1, 0, 3, 1, 1, 0);
        hold(12, 3, 1, 1, 0);

        // Abort at edge 5 of a DIV=1, NBITS=3 transfer
        step(0, 1, 0, 1, 0, 1, 3);
        hold(4, 1, 0, 1, 3);
        step(0, 0, 1, 1, 0, 1, 3);
        hold(6, 1, 0, 1, 3);

        // Config churn and START pulses mid-transfer
        step(0, 1, 0, 1, 0, 0, 3);
        for (int i = 0; i < 14; i++)
            step(0, bit'($urandom % 2), 0, $urandom % 16, bit'($urandom % 2),
                 bit'($urandom % 2), $urandom % 8);
        hold(6, 0, 0, 0, 0);

        // Back-to-back: START held through DONE cycles
        for (int i = 0; i < 16; i++) step(0, 1, 0, 0, 1, 0, 1);
        hold(6, 0, 1, 0, 1);

        // Reset at edge 6 of DIV=2, NBITS=5, then CPOL=1 idle and a fresh start
        step(0, 1, 0, 2, 0, 0, 5);
        hold(5, 2, 0, 0, 5);
        step(1, 0, 0, 2, 0, 0, 5);
        hold(2, 2, 1, 0, 5);
        step(0, 1, 0, 2, 0, 0, 5);
        hold(40, 2, 0, 0, 5);

        // START and ABORT together while idle
        step(0, 1, 1, 0, 1, 1, 2);
        hold(3, 0, 0, 0, 0);

        // NBITS all-ones at DIV=0: full 8 periods without wrap
        step(0, 1, 0, 0, 0, 1, 7);
        hold(18, 0, 0, 1, 7);

        // Randomised traffic
        for (int i = 0; i < 4000; i++) begin
            dv = ($urandom % 4 == 0) ? $urandom % 16 : $urandom % 3;
            nb = $urandom % 8;
            cp = bit'($urandom % 2);
            ch = bit'($urandom % 2);
            step(($urandom % 400) == 0, ($urandom % 4) == 0, ($urandom % 60) == 0,
                 dv, cp, ch, nb);
        end

        guard = 0;
        while (q.size() > 0 && guard < 600) begin
            step(0, 0, 0, 0, 0, 0, 0);
            guard++;
        end
        hold(3, 0, 0, 0, 0);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got %0d pending events want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
